// File: rtl/mem_if_pkg.sv
// Constants and state encoding for the cache block-refill memory interface.
// The caches import ADDR_W and BLOCK_W from here as well.
package mem_if_pkg;

   localparam int unsigned ADDR_W      = 28;
   localparam int unsigned BLOCK_W     = 128;
   localparam int unsigned LATENCY_MAX = 255;
   localparam int unsigned CNT_W       = $clog2(LATENCY_MAX + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_READY   = 2'd2,
      ST_RELEASE = 2'd3
   } resp_state_e;

endpackage

// File: rtl/mem_block_array.sv
// Block store: 2^IDX_W x BLOCK_W, with one synchronous write port and one
// synchronous read port. Only the read register is reset; the contents are not.
module mem_block_array #(
   parameter int unsigned IDX_W   = 6,
   parameter int unsigned BLOCK_W = 128
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en_i,
   input  logic [IDX_W-1:0]   wr_idx_i,
   input  logic [BLOCK_W-1:0] wr_data_i,
   input  logic               rd_en_i,
   input  logic [IDX_W-1:0]   rd_idx_i,
   output logic [BLOCK_W-1:0] rd_data_o
);

   localparam int unsigned DEPTH = 1 << IDX_W;

   logic [BLOCK_W-1:0] store_q [DEPTH];
   logic [BLOCK_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         store_q[wr_idx_i] <= wr_data_i;
      end
   end

   // Read register only loads on rd_en, so it holds the last read block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= store_q[rd_idx_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mem_block_responder.sv
// Memory-side responder for the cache block-refill interface: latches a
// request, waits a fixed latency, then reads or writes the block store.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for mem_read or mem_write
// BUSY       | request latched, latency counter running down
// READY      | mem_ready pulse cycle (store access done on entry)
// RELEASE    | waiting for the requester to drop both request lines
module mem_block_responder #(
   parameter int unsigned LATENCY = 8,
   parameter int unsigned IDX_W   = 6,
   parameter int unsigned ADDR_W  = mem_if_pkg::ADDR_W,
   parameter int unsigned BLOCK_W = mem_if_pkg::BLOCK_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [ADDR_W-1:0]  mem_addr,
   input  logic [BLOCK_W-1:0] mem_wdata,
   output logic [BLOCK_W-1:0] mem_rdata,
   output logic               mem_ready,
   output logic               busy
);

   import mem_if_pkg::*;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   resp_state_e        state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               op_wr_q;
   logic [IDX_W-1:0]   idx_q;
   logic [BLOCK_W-1:0] wdata_q;
   logic               mem_ready_q;
   logic               busy_q;

   logic               access_d;
   logic               arr_wr_en_d;
   logic               arr_rd_en_d;

   logic               unused_addr_hi;

   // Upper address bits alias onto the same store entries.
   assign unused_addr_hi = ^mem_addr[ADDR_W-1:IDX_W];

   // Store access fires on the last BUSY edge, driven only from registers.
   always_comb begin
      access_d    = (state_q == ST_BUSY) && (cnt_q == '0);
      arr_wr_en_d = access_d && op_wr_q;
      arr_rd_en_d = access_d && !op_wr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         op_wr_q     <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         mem_ready_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         mem_ready_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (mem_read || mem_write) begin
                  op_wr_q <= mem_write;
                  idx_q   <= mem_addr[IDX_W-1:0];
                  wdata_q <= mem_wdata;
                  cnt_q   <= CNT_LOAD;
                  state_q <= ST_BUSY;
                  busy_q  <= 1'b1;
               end
            end
            ST_BUSY: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  state_q     <= ST_READY;
                  mem_ready_q <= 1'b1;
               end
            end
            ST_READY: begin
               state_q <= ST_RELEASE;
            end
            ST_RELEASE: begin
               if (!mem_read && !mem_write) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   mem_block_array #(
      .IDX_W   (IDX_W),
      .BLOCK_W (BLOCK_W)
   ) u_array (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (arr_wr_en_d),
      .wr_idx_i  (idx_q),
      .wr_data_i (wdata_q),
      .rd_en_i   (arr_rd_en_d),
      .rd_idx_i  (idx_q),
      .rd_data_o (mem_rdata)
   );

   assign mem_ready = mem_ready_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_block_responder.sv
// Directed bench for mem_block_responder: one instance at LATENCY=4, one at LATENCY=1.
module tb_mem_block_responder;

   localparam int unsigned AW = 28;
   localparam int unsigned BW = 128;

   localparam logic [BW-1:0] D1  = {32'd4, 32'd3, 32'd2, 32'd1};
   localparam logic [BW-1:0] DA  = {4{32'hAAAA_AAAA}};
   localparam logic [BW-1:0] D5  = {4{32'h5555_5555}};
   localparam logic [BW-1:0] D3  = {4{32'h3333_3333}};
   localparam logic [BW-1:0] DX  = {4{32'hDEAD_BEEF}};
   localparam logic [BW-1:0] D7  = {32'h0707_0004, 32'h0707_0003, 32'h0707_0002, 32'h0707_0001};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n [2];
   logic          rd    [2];
   logic          wr    [2];
   logic [AW-1:0] addr  [2];
   logic [BW-1:0] wdata [2];
   logic [BW-1:0] rdata [2];
   logic          ready [2];
   logic          bsy   [2];

   int vectors     = 0;
   int miscompares = 0;

   mem_block_responder #(.LATENCY(4), .IDX_W(6)) u_dut_l4 (
      .clk       (clk),
      .rst_n     (rst_n[0]),
      .mem_read  (rd[0]),
      .mem_write (wr[0]),
      .mem_addr  (addr[0]),
      .mem_wdata (wdata[0]),
      .mem_rdata (rdata[0]),
      .mem_ready (ready[0]),
      .busy      (bsy[0])
   );

   mem_block_responder #(.LATENCY(1), .IDX_W(6)) u_dut_l1 (
      .clk       (clk),
      .rst_n     (rst_n[1]),
      .mem_read  (rd[1]),
      .mem_write (wr[1]),
      .mem_addr  (addr[1]),
      .mem_wdata (wdata[1]),
      .mem_rdata (rdata[1]),
      .mem_ready (ready[1]),
      .busy      (bsy[1])
   );

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Raise a request, scramble addr/data after acceptance, and count edges
   // after acceptance until mem_ready is seen. Returns at that negedge.
   task automatic do_req(input int d, input logic w, input logic r,
                         input logic [AW-1:0] a, input logic [BW-1:0] wd, output int lat);
      @(negedge clk);
      wr[d] = w; rd[d] = r; addr[d] = a; wdata[d] = wd;
      @(posedge clk);
      lat = 0;
      forever begin
         @(negedge clk);
         addr[d]  = ~a;
         wdata[d] = ~wd;
         if (ready[d] === 1'b1 || lat >= 64) break;
         @(posedge clk);
         lat++;
      end
   endtask

   // Check the pulse ends, drop the request, and check IDLE one edge later.
   task automatic finish_req(input int d, input string tag);
      @(negedge clk);
      chk({tag, "_pulse_end"}, ready[d], 1'b0);
      chk({tag, "_busy_held"}, bsy[d], 1'b1);
      wr[d] = 1'b0; rd[d] = 1'b0;
      @(negedge clk);
      chk({tag, "_idle"}, bsy[d], 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int pulses;
      for (int i = 0; i < 2; i++) begin
         rst_n[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      end
      repeat (2) @(negedge clk);
      chk("rst_rdata", rdata[0], '0);
      chk("rst_ready", ready[0], 1'b0);
      chk("rst_busy",  bsy[0],   1'b0);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      @(negedge clk);

      // Write words 1..4 to block 5.
      do_req(0, 1'b1, 1'b0, 28'h000_0005, D1, lat);
      chk("wr5_latency", lat, 4);
      chk("wr5_busy", bsy[0], 1'b1);
      finish_req(0, "wr5");

      // Read block 5 back, hold mem_read for 5 cycles after the pulse.
      do_req(0, 1'b0, 1'b1, 28'h000_0005, '0, lat);
      chk("rd5_latency", lat, 4);
      chk("rd5_data", rdata[0], D1);
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (ready[0] === 1'b1) pulses++;
      end
      chk("rd5_no_second_ready", pulses, 0);
      chk("rd5_busy_while_held", bsy[0], 1'b1);
      rd[0] = 1'b0;
      @(negedge clk);
      chk("rd5_idle_after_drop", bsy[0], 1'b0);
      repeat (3) @(negedge clk);
      chk("rd5_data_stable", rdata[0], D1);

      // Aliasing: 0x41 and 0x01 share index 1.
      do_req(0, 1'b1, 1'b0, 28'h000_0041, DA, lat);
      chk("wr41_latency", lat, 4);
      finish_req(0, "wr41");
      do_req(0, 1'b0, 1'b1, 28'h000_0001, '0, lat);
      chk("rd01_alias_data", rdata[0], DA);
      finish_req(0, "rd01");

      // Read and write together: write wins, mem_rdata untouched.
      do_req(0, 1'b1, 1'b1, 28'h000_0002, D5, lat);
      chk("both_latency", lat, 4);
      chk("both_rdata_kept", rdata[0], DA);
      finish_req(0, "both");
      chk("both_rdata_kept_after", rdata[0], DA);
      do_req(0, 1'b0, 1'b1, 28'h000_0002, '0, lat);
      chk("rd2_data", rdata[0], D5);
      finish_req(0, "rd2");

      // Reset one cycle into BUSY of a write to block 3 loses that write.
      do_req(0, 1'b1, 1'b0, 28'h000_0003, D3, lat);
      finish_req(0, "wr3");
      @(negedge clk);
      wr[0] = 1'b1; addr[0] = 28'h000_0003; wdata[0] = DX;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_mid_busy_before", bsy[0], 1'b1);
      rst_n[0] = 1'b0;
      #1;
      chk("rst_mid_busy", bsy[0], 1'b0);
      chk("rst_mid_ready", ready[0], 1'b0);
      chk("rst_mid_rdata", rdata[0], '0);
      wr[0] = 1'b0;
      @(negedge clk);
      rst_n[0] = 1'b1;
      @(negedge clk);
      do_req(0, 1'b0, 1'b1, 28'h000_0003, '0, lat);
      chk("rd3_old_value", rdata[0], D3);
      finish_req(0, "rd3");

      // LATENCY=1 instance.
      do_req(1, 1'b1, 1'b0, 28'h000_0007, D7, lat);
      chk("l1_wr_latency", lat, 1);
      finish_req(1, "l1_wr");
      do_req(1, 1'b0, 1'b1, 28'h000_0007, '0, lat);
      chk("l1_rd_latency", lat, 1);
      chk("l1_rd_data", rdata[1], D7);
      finish_req(1, "l1_rd");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
